pwm_multi: RTL and testbench

- N-channel PWM generator built around one shared period counter.
- Each channel has its own duty value. Period and duty are both programmable at run time.
- Writes go to shadow registers and take effect only at a period boundary (glitch-free).
- Drives LED/heater/bias PWM outputs in the bolometer front end. Replaces the fixed 4-level single-channel PWM.

---
 rtl/pwm_multi.sv | 132 +++++++++++++
 tb/tb_pwm_multi.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM generator sharing one period counter.
// Period and duty writes land in shadow registers and are copied into the
// active registers only at a period boundary, so outputs never glitch.
module pwm_multi #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE   = 1,
  parameter int PERIOD_RST = 99,
  localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                period_we_i,
  input  logic [WIDTH-1:0]    period_i,
  input  logic                duty_we_i,
  input  logic [SEL_W-1:0]    duty_sel_i,
  input  logic [WIDTH-1:0]    duty_i,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                wrap_o,
  output logic                pend_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_MAX   = PW'(PRESCALE - 1);
  localparam logic [SEL_W:0]   NUM_CH      = (SEL_W + 1)'(CHANNELS);
  localparam logic [WIDTH-1:0] PERIOD_INIT = WIDTH'(PERIOD_RST);

  logic [PW-1:0]       presc_q, presc_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    period_act_q, period_act_d;
  logic [WIDTH-1:0]    period_pend_q, period_pend_d;
  logic [WIDTH-1:0]    duty_act_q  [CHANNELS];
  logic [WIDTH-1:0]    duty_act_d  [CHANNELS];
  logic [WIDTH-1:0]    duty_pend_q [CHANNELS];
  logic [WIDTH-1:0]    duty_pend_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                wrap_q, wrap_d;
  logic                pend_q, pend_d;

  logic tick;
  logic wrapEvent;
  logic load;
  logic dutyAccept;
  logic anyAccept;

  // Next-state logic: prescaler, shared counter, shadow-to-active load,
  // pending flag and the per-channel compare feeding the output registers.
  always_comb begin
    tick          = (presc_q == PRESC_MAX);
    wrapEvent     = en_i && tick && (cnt_q == period_act_q);
    // While disabled, load every clock so fresh writes take effect at once.
    load          = !en_i || wrapEvent;
    dutyAccept    = duty_we_i && ({1'b0, duty_sel_i} < NUM_CH);
    anyAccept     = period_we_i || dutyAccept;

    presc_d       = presc_q;
    cnt_d         = cnt_q;
    period_act_d  = period_act_q;
    period_pend_d = period_pend_q;
    duty_act_d    = duty_act_q;
    duty_pend_d   = duty_pend_q;
    pwm_d         = '0;
    wrap_d        = wrapEvent;
    pend_d        = pend_q;

    if (!en_i) begin
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        cnt_d = (cnt_q == period_act_q) ? '0 : cnt_q + WIDTH'(1);
      end
    end

    // The load copies the pre-edge shadow values; a write on the same
    // clock only updates the shadow and waits for the following load.
    if (load) begin
      period_act_d = period_pend_q;
      duty_act_d   = duty_pend_q;
    end

    if (period_we_i) begin
      period_pend_d = period_i;
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (dutyAccept && (duty_sel_i == SEL_W'(k))) begin
        duty_pend_d[k] = duty_i;
      end
      pwm_d[k] = en_i && (cnt_q < duty_act_q[k]);
    end

    if (anyAccept) begin
      pend_d = 1'b1;
    end else if (load) begin
      pend_d = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q       <= '0;
      cnt_q         <= '0;
      period_act_q  <= PERIOD_INIT;
      period_pend_q <= PERIOD_INIT;
      for (int k = 0; k < CHANNELS; k++) begin
        duty_act_q[k]  <= '0;
        duty_pend_q[k] <= '0;
      end
      pwm_q         <= '0;
      wrap_q        <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      period_act_q  <= period_act_d;
      period_pend_q <= period_pend_d;
      duty_act_q    <= duty_act_d;
      duty_pend_q   <= duty_pend_d;
      pwm_q         <= pwm_d;
      wrap_q        <= wrap_d;
      pend_q        <= pend_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign wrap_o = wrap_q;
  assign pend_o = pend_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: drives two pwm_multi instances (4 ch / no prescale and
// 3 ch / prescale 4) with the same stimulus and checks both against a
// clock-count reference model plus scenario-specific counts.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       pwe = 1'b0;
  logic [7:0] pin = '0;
  logic       dwe = 1'b0;
  logic [1:0] dsel = '0;
  logic [7:0] din = '0;

  logic [3:0] pwmA;
  logic       wrapA, pendA;
  logic [2:0] pwmB;
  logic       wrapB, pendB;

  int checks   = 0;
  int failures = 0;

  pwm_multi #(.WIDTH(8), .CHANNELS(4), .PRESCALE(1), .PERIOD_RST(99)) dutA (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .period_we_i(pwe), .period_i(pin),
    .duty_we_i(dwe), .duty_sel_i(dsel), .duty_i(din),
    .pwm_o(pwmA), .wrap_o(wrapA), .pend_o(pendA)
  );

  pwm_multi #(.WIDTH(8), .CHANNELS(3), .PRESCALE(4), .PERIOD_RST(99)) dutB (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .period_we_i(pwe), .period_i(pin),
    .duty_we_i(dwe), .duty_sel_i(dsel), .duty_i(din),
    .pwm_o(pwmB), .wrap_o(wrapB), .pend_o(pendB)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Reference model: each instance tracks the clocks elapsed in the current
  // period; the counter value is elapsed/prescale and the period lasts
  // (period+1)*prescale clocks.
  int         mEl  [2];
  int         mPa  [2];
  int         mPp  [2];
  int         mDa  [2][4];
  int         mDp  [2][4];
  logic [3:0] mPwm [2];
  logic       mWrap[2];
  logic       mPend[2];

  // Advance the model one clock, using pre-edge inputs and state.
  always @(posedge clk or posedge rst) begin : model
    int s, nch, len, cnt;
    logic wrapNow, loadNow, acc;
    logic [3:0] p;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mEl[i] <= 0; mPa[i] <= 99; mPp[i] <= 99;
        mPwm[i] <= '0; mWrap[i] <= 1'b0; mPend[i] <= 1'b0;
        for (int k = 0; k < 4; k++) begin
          mDa[i][k] <= 0; mDp[i][k] <= 0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        s       = (i == 0) ? 1 : 4;
        nch     = (i == 0) ? 4 : 3;
        cnt     = mEl[i] / s;
        len     = (mPa[i] + 1) * s;
        wrapNow = en && (mEl[i] == len - 1);
        loadNow = !en || wrapNow;
        p       = '0;
        for (int k = 0; k < nch; k++) p[k] = en && (cnt < mDa[i][k]);
        acc     = pwe || (dwe && (int'(dsel) < nch));
        mPwm[i]  <= p;
        mWrap[i] <= wrapNow;
        mPend[i] <= acc ? 1'b1 : (loadNow ? 1'b0 : mPend[i]);
        mPa[i]   <= loadNow ? mPp[i] : mPa[i];
        mPp[i]   <= pwe ? int'(pin) : mPp[i];
        for (int k = 0; k < 4; k++) begin
          mDa[i][k] <= loadNow ? mDp[i][k] : mDa[i][k];
          mDp[i][k] <= (dwe && int'(dsel) == k && k < nch) ? int'(din) : mDp[i][k];
        end
        mEl[i]   <= (!en || wrapNow) ? 0 : mEl[i] + 1;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; pwe = 1'b0; dwe = 1'b0;
    #1 rst = 1'b1;
    #20;
    checks++;
    if ({pwmA, wrapA, pendA} !== 6'b0) begin
      failures++; $display("FAIL reset_outA got=%b exp=000000", {pwmA, wrapA, pendA});
    end
    checks++;
    if ({pwmB, wrapB, pendB} !== 5'b0) begin
      failures++; $display("FAIL reset_outB got=%b exp=00000", {pwmB, wrapB, pendB});
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({pwmA, wrapA, pendA} !== {mPwm[0], mWrap[0], mPend[0]}) begin
        failures++; $display("FAIL reset_modelA t=%0t got=%b exp=%b", $time, {pwmA, wrapA, pendA}, {mPwm[0], mWrap[0], mPend[0]});
      end
    end
  endtask

  task automatic test_basic_duty();
    int hi = 0, wr = 0;
    bit found = 0;
    @(negedge clk); en = 1'b1; dwe = 1'b1; dsel = 2'd0; din = 8'd25;
    @(negedge clk); dwe = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (wrapA) begin found = 1; break; end
      @(negedge clk);
      checks++;
      if ({pwmA, wrapA, pendA} !== {mPwm[0], mWrap[0], mPend[0]}) begin
        failures++; $display("FAIL basic_modelA t=%0t got=%b exp=%b", $time, {pwmA, wrapA, pendA}, {mPwm[0], mWrap[0], mPend[0]});
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL basic_wrap_timeout got=0 exp=1"); end
    for (int s = 1; s <= 100; s++) begin
      @(negedge clk);
      if (pwmA[0]) hi++;
      if (wrapA) wr++;
      checks++;
      if ({pwmA, wrapA, pendA} !== {mPwm[0], mWrap[0], mPend[0]}) begin
        failures++; $display("FAIL basic_modelA t=%0t got=%b exp=%b", $time, {pwmA, wrapA, pendA}, {mPwm[0], mWrap[0], mPend[0]});
      end
    end
    checks++;
    if (hi != 25) begin failures++; $display("FAIL basic_high_count got=%0d exp=25", hi); end
    checks++;
    if (wr != 1) begin failures++; $display("FAIL basic_wrap_count got=%0d exp=1", wr); end
  endtask

  task automatic test_duty_channels();
    int hi[4];
    int exp[4] = '{0, 50, 100, 100};
    logic [7:0] val[4] = '{8'd0, 8'd50, 8'd100, 8'd255};
    bit found = 0;
    repeat ($urandom_range(0, 60)) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      dwe = 1'b1; dsel = 2'(k); din = val[k];
      @(negedge clk);
    end
    dwe = 1'b0;
    checks++;
    if (pendA !== 1'b1) begin failures++; $display("FAIL chan_pend_set got=%b exp=1", pendA); end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if ({pwmB, wrapB, pendB} !== {mPwm[1][2:0], mWrap[1], mPend[1]}) begin
        failures++; $display("FAIL chan_modelB t=%0t got=%b exp=%b", $time, {pwmB, wrapB, pendB}, {mPwm[1][2:0], mWrap[1], mPend[1]});
      end
      if (wrapA) begin found = 1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL chan_wrap_timeout got=0 exp=1"); end
    checks++;
    if (pendA !== 1'b0) begin failures++; $display("FAIL chan_pend_clear got=%b exp=0", pendA); end
    for (int k = 0; k < 4; k++) hi[k] = 0;
    for (int s = 1; s <= 100; s++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (pwmA[k]) hi[k]++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (hi[k] != exp[k]) begin
        failures++; $display("FAIL chan_high_count ch=%0d got=%0d exp=%0d", k, hi[k], exp[k]);
      end
    end
  endtask

  task automatic test_shadow_update();
    int hiA = 0, hiB = 0, pendHigh = 0;
    logic pendAt100 = 1'bx;
    for (int s = 0; s < 200; s++) begin
      if (s == 20) begin dwe = 1'b1; dsel = 2'd1; din = 8'd10; end
      if (s == 21) dwe = 1'b0;
      @(negedge clk);
      if (s + 1 <= 100 && pwmA[1]) hiA++;
      if (s + 1 > 100 && pwmA[1]) hiB++;
      if (s + 1 >= 21 && s + 1 <= 99 && pendA) pendHigh++;
      if (s + 1 == 100) pendAt100 = pendA;
      checks++;
      if ({pwmA, wrapA, pendA} !== {mPwm[0], mWrap[0], mPend[0]}) begin
        failures++; $display("FAIL shadow_modelA t=%0t got=%b exp=%b", $time, {pwmA, wrapA, pendA}, {mPwm[0], mWrap[0], mPend[0]});
      end
    end
    checks++;
    if (hiA != 50) begin failures++; $display("FAIL shadow_old_high got=%0d exp=50", hiA); end
    checks++;
    if (hiB != 10) begin failures++; $display("FAIL shadow_new_high got=%0d exp=10", hiB); end
    checks++;
    if (pendHigh != 79) begin failures++; $display("FAIL shadow_pend_window got=%0d exp=79", pendHigh); end
    checks++;
    if (pendAt100 !== 1'b0) begin failures++; $display("FAIL shadow_pend_at_wrap got=%b exp=0", pendAt100); end
  endtask

  task automatic test_write_collision();
    int wr = 0;
    logic pendAt100 = 1'bx, pendAt200 = 1'bx, w200 = 1'bx, w210 = 1'bx;
    for (int s = 0; s < 230; s++) begin
      if (s == 99) begin pwe = 1'b1; pin = 8'd9; end
      if (s == 100) pwe = 1'b0;
      @(negedge clk);
      if (wrapA) wr++;
      if (s + 1 == 100) pendAt100 = pendA;
      if (s + 1 == 200) begin pendAt200 = pendA; w200 = wrapA; end
      if (s + 1 == 210) w210 = wrapA;
      checks++;
      if ({pwmA, wrapA, pendA} !== {mPwm[0], mWrap[0], mPend[0]}) begin
        failures++; $display("FAIL collide_modelA t=%0t got=%b exp=%b", $time, {pwmA, wrapA, pendA}, {mPwm[0], mWrap[0], mPend[0]});
      end
    end
    checks++;
    if (wr != 5) begin failures++; $display("FAIL collide_wrap_count got=%0d exp=5", wr); end
    checks++;
    if (pendAt100 !== 1'b1) begin failures++; $display("FAIL collide_pend_kept got=%b exp=1", pendAt100); end
    checks++;
    if (pendAt200 !== 1'b0) begin failures++; $display("FAIL collide_pend_clear got=%b exp=0", pendAt200); end
    checks++;
    if ({w200, w210} !== 2'b11) begin failures++; $display("FAIL collide_short_period got=%b exp=11", {w200, w210}); end
  endtask

  task automatic test_prescale();
    int found = 0, hi = 0, wr = 0;
    @(negedge clk); dwe = 1'b1; dsel = 2'd0; din = 8'd3;
    @(negedge clk); dwe = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks++;
      if ({pwmB, wrapB, pendB} !== {mPwm[1][2:0], mWrap[1], mPend[1]}) begin
        failures++; $display("FAIL presc_modelB t=%0t got=%b exp=%b", $time, {pwmB, wrapB, pendB}, {mPwm[1][2:0], mWrap[1], mPend[1]});
      end
      if (wrapB) found++;
      if (found == 2) break;
    end
    checks++;
    if (found != 2) begin failures++; $display("FAIL presc_wrap_timeout got=%0d exp=2", found); end
    for (int s = 1; s <= 40; s++) begin
      @(negedge clk);
      if (pwmB[0]) hi++;
      if (wrapB) wr++;
    end
    checks++;
    if (hi != 12) begin failures++; $display("FAIL presc_high_count got=%0d exp=12", hi); end
    checks++;
    if (wr != 1) begin failures++; $display("FAIL presc_wrap_count got=%0d exp=1", wr); end
  endtask

  task automatic test_disable();
    int hi = 0, wrOff = 0, firstWrap = 0;
    repeat ($urandom_range(2, 30)) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({pwmA, pwmB} !== 7'b0) begin failures++; $display("FAIL disable_pwm_low got=%b exp=0000000", {pwmA, pwmB}); end
    repeat (5) begin
      @(negedge clk);
      if (wrapA || wrapB) wrOff++;
    end
    checks++;
    if (wrOff != 0) begin failures++; $display("FAIL disable_no_wrap got=%0d exp=0", wrOff); end
    en = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      if (pwmA[0]) hi++;
      if (wrapA && firstWrap == 0) firstWrap = s;
      checks++;
      if ({pwmB, wrapB, pendB} !== {mPwm[1][2:0], mWrap[1], mPend[1]}) begin
        failures++; $display("FAIL disable_modelB t=%0t got=%b exp=%b", $time, {pwmB, wrapB, pendB}, {mPwm[1][2:0], mWrap[1], mPend[1]});
      end
    end
    checks++;
    if (hi != 3) begin failures++; $display("FAIL restart_high_count got=%0d exp=3", hi); end
    checks++;
    if (firstWrap != 10) begin failures++; $display("FAIL restart_first_wrap got=%0d exp=10", firstWrap); end
  endtask

  task automatic test_reset_mid();
    int wrapAt = 0;
    repeat ($urandom_range(3, 7)) @(negedge clk);
    pwe = 1'b1; pin = 8'd5;
    @(negedge clk); pwe = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pwmA, wrapA, pendA, pwmB, wrapB, pendB} !== 11'b0) begin
      failures++; $display("FAIL reset_mid_outputs got=%b exp=0", {pwmA, wrapA, pendA, pwmB, wrapB, pendB});
    end
    @(negedge clk); rst = 1'b0;
    for (int s = 1; s <= 300; s++) begin
      @(negedge clk);
      checks++;
      if ({pwmA, wrapA, pendA} !== {mPwm[0], mWrap[0], mPend[0]}) begin
        failures++; $display("FAIL reset_mid_modelA t=%0t got=%b exp=%b", $time, {pwmA, wrapA, pendA}, {mPwm[0], mWrap[0], mPend[0]});
      end
      if (wrapA) begin wrapAt = s; break; end
    end
    checks++;
    if (wrapAt != 100) begin failures++; $display("FAIL reset_mid_period got=%0d exp=100", wrapAt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      en   = ($urandom_range(0, 99) < 95);
      pwe  = ($urandom_range(0, 99) < 4);
      pin  = 8'($urandom_range(0, 30));
      dwe  = ($urandom_range(0, 99) < 12);
      dsel = 2'($urandom_range(0, 3));
      din  = 8'($urandom_range(0, 40));
      @(negedge clk);
      checks++;
      if ({pwmA, wrapA, pendA} !== {mPwm[0], mWrap[0], mPend[0]}) begin
        failures++; $display("FAIL random_modelA t=%0t got=%b exp=%b", $time, {pwmA, wrapA, pendA}, {mPwm[0], mWrap[0], mPend[0]});
      end
      checks++;
      if ({pwmB, wrapB, pendB} !== {mPwm[1][2:0], mWrap[1], mPend[1]}) begin
        failures++; $display("FAIL random_modelB t=%0t got=%b exp=%b", $time, {pwmB, wrapB, pendB}, {mPwm[1][2:0], mWrap[1], mPend[1]});
      end
    end
    pwe = 1'b0; dwe = 1'b0;
  endtask

  // Sequence the scenarios and report.
  initial begin
    test_reset();
    test_basic_duty();
    test_duty_channels();
    test_shadow_update();
    test_write_collision();
    test_prescale();
    test_disable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
